// File: rtl/jtag_cmd_pkg.sv
// jtag_cmd_pkg: shared encodings, widths and status layout for the JTAG command controller
package jtag_cmd_pkg;
  localparam int DR_W = 32;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W = 5;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam logic [DATA_W-1:0] FILL_RDATA = 16'hDEAD;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_CLEAR = 2'b11} op_e;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ = 2'd1;
  localparam state_t S_DONE = 2'd2;
  // field order fixes the status word layout, MSB first
  typedef struct packed {
    logic busy;
    logic timeout_err;
    logic overrun;
    logic [CNT_W-1:0] txn_count;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_rdata;
  } status_t;
endpackage

// File: rtl/jtag_user_dr.sv
// jtag_user_dr: 32-bit capture/shift user data register behind one JTAGG chain
module jtag_user_dr
  import jtag_cmd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            shift,
  input  logic            tdi,
  input  logic [DR_W-1:0] capture,
  output logic [DR_W-1:0] sr
);
  always_ff @(posedge clk)
    if (rst) sr <= '0;
    else if (ce) sr <= shift ? {tdi, sr[DR_W-1:1]} : capture;
endmodule

// File: rtl/jtag_cmd_controller.sv
// jtag_cmd_controller: turns ER1 command scans into bus transactions and reports status on ER2
module jtag_cmd_controller
  import jtag_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              JTCK,
  input  logic              reset,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JCE1,
  input  logic              JCE2,
  output logic              JTDO1,
  output logic              JTDO2,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [DR_W-1:0] sr1, sr2;
  state_t state;
  logic sel_er2, timeout_err, overrun, upd, tmo_hit, unused_ok;
  logic [CNT_W-1:0] txn_count;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_rdata;
  logic [TW-1:0] tmo_cnt;
  op_e op;
  status_t status;
  assign busy = state != S_IDLE;
  assign op = op_e'(sr1[31:30]);
  assign upd = JUPDATE && !sel_er2;
  assign tmo_hit = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign status = {busy, timeout_err, overrun, txn_count, last_addr, last_rdata};
  assign JTDO1 = sr1[0];
  assign JTDO2 = sr2[0];
  assign unused_ok = ^{sr1[29:24], sr2[DR_W-1:1]};
  jtag_user_dr u_er1 (.clk(JTCK), .rst(reset), .ce(JCE1), .shift(JSHIFT), .tdi(JTDI), .capture('0), .sr(sr1));
  jtag_user_dr u_er2 (.clk(JTCK), .rst(reset), .ce(JCE2), .shift(JSHIFT), .tdi(JTDI), .capture(status), .sr(sr2));
  always_ff @(posedge JTCK)
    if (reset) begin
      state <= S_IDLE;
      sel_er2 <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      timeout_err <= 1'b0;
      overrun <= 1'b0;
      txn_count <= '0;
      last_addr <= '0;
      last_rdata <= '0;
      tmo_cnt <= '0;
    end else begin
      if (JCE1) sel_er2 <= 1'b0;
      else if (JCE2) sel_er2 <= 1'b1;
      if (upd && state != S_IDLE) overrun <= 1'b1;
      if (state == S_IDLE && upd && (op == OP_WRITE || op == OP_READ)) begin
        state <= S_REQ;
        bus_req <= 1'b1;
        bus_we <= op == OP_WRITE;
        bus_addr <= sr1[23:16];
        bus_wdata <= sr1[15:0];
        tmo_cnt <= '0;
      end else if (state == S_IDLE && upd && op == OP_CLEAR) begin
        timeout_err <= 1'b0;
        overrun <= 1'b0;
        txn_count <= '0;
      end else if (state == S_REQ) begin
        // ack is checked first so a coincident ack beats the timeout
        if (bus_ack || tmo_hit) begin
          state <= S_DONE;
          bus_req <= 1'b0;
          last_addr <= bus_addr;
          if (!bus_ack) timeout_err <= 1'b1;
          if (!bus_ack) last_rdata <= FILL_RDATA;
          else if (!bus_we) last_rdata <= bus_rdata;
        end else tmo_cnt <= tmo_cnt + 1'b1;
      end else if (state == S_DONE) begin
        state <= S_IDLE;
        txn_count <= txn_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_jtag_cmd_controller.sv
// tb_jtag_cmd_controller: randomized transactions checked against a field-level status model
module tb_jtag_cmd_controller;
  localparam int T = 255;
  logic JTCK = 1'b0, reset = 1'b1, JTDI = 1'b0, JSHIFT = 1'b0, JUPDATE = 1'b0, JCE1 = 1'b0, JCE2 = 1'b0;
  logic bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic JTDO1, JTDO2, bus_req, bus_we, busy;
  logic [7:0] bus_addr;
  logic [15:0] bus_wdata;
  int n_tests = 0, n_fail = 0;
  bit m_tmo, m_ovr;
  int m_cnt;
  logic [7:0] m_addr;
  logic [15:0] m_rdata;
  logic [31:0] st;
  always #5 JTCK = ~JTCK;
  jtag_cmd_controller #(.TIMEOUT_CYCLES(T)) dut (
    .JTCK(JTCK), .reset(reset), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE), .JCE1(JCE1), .JCE2(JCE2),
    .JTDO1(JTDO1), .JTDO2(JTDO2), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge JTCK);
    #1;
  endtask
  function automatic logic [31:0] model_status();
    return {1'b0, m_tmo, m_ovr, 5'(m_cnt % 32), m_addr, m_rdata};
  endfunction
  task automatic model_reset;
    m_tmo = 0; m_ovr = 0; m_cnt = 0; m_addr = '0; m_rdata = '0;
  endtask
  task automatic shift_er1(input logic [31:0] w);
    JCE1 = 1; JSHIFT = 0; tick;
    JSHIFT = 1;
    for (int i = 0; i < 32; i++) begin JTDI = w[i]; tick; end
    JCE1 = 0; JSHIFT = 0; JTDI = 0;
    check("jtdo1", 32'(JTDO1), 32'(w[0]));
  endtask
  task automatic read_status(output logic [31:0] w);
    JCE2 = 1; JSHIFT = 0; tick;
    JSHIFT = 1;
    for (int i = 0; i < 32; i++) begin w[i] = JTDO2; JTDI = 1'($urandom); tick; end
    JCE2 = 0; JSHIFT = 0; JTDI = 0;
  endtask
  task automatic run_txn(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data,
                         input int ack_at, input logic [15:0] rdata, input bit ovr_poke, input bit chk);
    int hi;
    bit acked;
    logic [31:0] s;
    shift_er1({op, 6'($urandom), addr, data});
    JUPDATE = 1;
    bus_ack = (op == 2'b00 || op == 2'b11) ? 1'($urandom) : 1'b0;
    tick;
    JUPDATE = 0; bus_ack = 0;
    if (op == 2'b01 || op == 2'b10) begin
      check("req_rise", 32'(bus_req), 32'd1);
      check("bus_we", 32'(bus_we), 32'(op == 2'b01));
      check("bus_addr", 32'(bus_addr), 32'(addr));
      check("bus_wdata", 32'(bus_wdata), 32'(data));
      hi = 0;
      while (bus_req && hi < T + 4) begin
        hi++;
        bus_ack = hi == ack_at;
        bus_rdata = bus_ack ? rdata : 16'($urandom);
        JUPDATE = ovr_poke && hi == 1;
        tick;
        if (bus_req) check("hold", {15'd0, bus_we, bus_addr, 8'd0}, {15'd0, op == 2'b01, addr, 8'd0});
      end
      bus_ack = 0; JUPDATE = 0;
      acked = ack_at >= 1 && ack_at <= T;
      check("req_cycles", 32'(hi), 32'(acked ? ack_at : T));
      check("busy_done", 32'(busy), 32'd1);
      tick;
      check("busy_idle", 32'(busy), 32'd0);
      m_cnt++;
      m_addr = addr;
      if (!acked) begin m_tmo = 1; m_rdata = 16'hDEAD; end
      else if (op == 2'b10) m_rdata = rdata;
      if (ovr_poke) m_ovr = 1;
    end else begin
      check("no_req", {30'd0, bus_req, busy}, 32'd0);
      if (op == 2'b11) begin m_tmo = 0; m_ovr = 0; m_cnt = 0; end
    end
    if (chk) begin
      read_status(s);
      check("status", s, model_status());
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    model_reset();
    repeat (3) tick;
    check("rst_outs", {25'd0, bus_req, bus_we, busy, JTDO1, JTDO2, 2'd0}, 32'd0);
    check("rst_bus", {bus_addr, bus_wdata, 8'd0}, 32'd0);
    reset = 0;
    tick;
    read_status(st);
    check("rst_status", st, 32'd0);
    run_txn(2'b01, 8'h12, 16'hABCD, 3, 16'h0, 0, 1);
    run_txn(2'b10, 8'h34, 16'h0000, 2, 16'h5A5A, 0, 1);
    run_txn(2'b10, 8'h56, 16'h1111, 0, 16'h0, 0, 1);
    run_txn(2'b11, 8'h00, 16'h0000, 0, 16'h0, 0, 1);
    run_txn(2'b01, 8'h77, 16'h1234, 5, 16'h0, 1, 1);
    run_txn(2'b10, 8'h9A, 16'h0000, T, 16'hBEEF, 0, 1);
    run_txn(2'b00, 8'hFF, 16'hFFFF, 1, 16'h0, 0, 1);
    // last scan selected ER2, so this update must be ignored
    JUPDATE = 1; tick; JUPDATE = 0;
    check("er2_upd_ignored", {30'd0, bus_req, busy}, 32'd0);
    tick;
    shift_er1({2'b10, 6'd0, 8'hC3, 16'h0});
    JUPDATE = 1; tick; JUPDATE = 0;
    check("rst_req_pre", 32'(bus_req), 32'd1);
    repeat (4) tick;
    reset = 1; tick;
    check("rst_in_req", {30'd0, bus_req, busy}, 32'd0);
    reset = 0; tick;
    check("rst_no_done", 32'(busy), 32'd0);
    model_reset();
    read_status(st);
    check("rst_req_status", st, model_status());
    run_txn(2'b11, 8'h00, 16'h0000, 0, 16'h0, 0, 0);
    for (int i = 0; i < 33; i++) run_txn(2'b01, 8'(i), 16'($urandom), 1, 16'h0, 0, 0);
    read_status(st);
    check("wrap_status", st, model_status());
    check("wrap_count", 32'(st[28:24]), 32'd1);
    for (int i = 0; i < 40; i++) begin
      int ack_at;
      ack_at = ($urandom_range(0, 7) == 0) ? 0 : ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(1, 6));
      run_txn(2'($urandom), 8'($urandom), 16'($urandom), ack_at, 16'($urandom),
              $urandom_range(0, 3) == 0, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
